// File: rtl/inst_group_splitter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : inst_group_splitter_pkg
// Purpose : Shared widths and helpers for the fetch-group splitter.
//           INST_W   - instruction word width
//           GROUP_W  - slots per fetch group
//           GRP_PC_W - group PC width (PC[31:4])
//           SLOT_W   - slot index width (PC[3:2])
// Revision: 1.0 - initial release
// ============================================================================
package inst_group_splitter_pkg;

  localparam int unsigned INST_W   = 32;
  localparam int unsigned GROUP_W  = 4;
  localparam int unsigned GRP_PC_W = 28;
  localparam int unsigned SLOT_W   = 2;

  // Number of set bits in a slot mask (0..4).
  function automatic logic [2:0] popcount_mask(input logic [GROUP_W-1:0] mask);
    logic [2:0] cnt;
    cnt = '0;
    for (int k = 0; k < int'(GROUP_W); k++) begin
      cnt = cnt + {2'b00, mask[k]};
    end
    return cnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_group_splitter_if.sv
`default_nettype none
// ============================================================================
// Module  : inst_group_splitter_if
// Purpose : Bundles the group-in handshake (from the instruction buffer) and
//           the lane-out handshake (to decode) of the splitter.
//   flush         - pipeline redirect
//   inst_4W       - 4 instructions, slot k at [32k+31:32k]
//   inst_4W_valid - slot valid mask
//   inst_4W_pc    - group PC[31:4]
//   pre_valid     - upstream has a group
//   out_ready     - group accepted this cycle
//   issue_inst    - lane instructions
//   issue_pc      - lane full PCs
//   issue_valid   - lane valids, contiguous from lane 0
//   out_valid     - any lane valid
//   next_ready    - decode accepts all valid lanes
// Modports: slave = splitter side, master = environment side.
// Revision: 1.0 - initial release
// ============================================================================
interface inst_group_splitter_if #(
  parameter int unsigned ISSUE_W = 2
) ();
  import inst_group_splitter_pkg::*;

  logic                          flush;
  logic [INST_W*GROUP_W-1:0]     inst_4W;
  logic [GROUP_W-1:0]            inst_4W_valid;
  logic [GRP_PC_W-1:0]           inst_4W_pc;
  logic                          pre_valid;
  logic                          out_ready;
  logic [INST_W*ISSUE_W-1:0]     issue_inst;
  logic [INST_W*ISSUE_W-1:0]     issue_pc;
  logic [ISSUE_W-1:0]            issue_valid;
  logic                          out_valid;
  logic                          next_ready;

  modport slave (
    input  flush, inst_4W, inst_4W_valid, inst_4W_pc, pre_valid, next_ready,
    output out_ready, issue_inst, issue_pc, issue_valid, out_valid
  );

  modport master (
    output flush, inst_4W, inst_4W_valid, inst_4W_pc, pre_valid, next_ready,
    input  out_ready, issue_inst, issue_pc, issue_valid, out_valid
  );

endinterface
`default_nettype wire

// File: rtl/inst_group_splitter_first_n_picker.sv
`default_nettype none
// ============================================================================
// Module  : first_n_picker
// Purpose : Combinational selector: for lane j, returns a one-hot select of
//           the j-th lowest set bit of mask (zero if fewer than j+1 bits set),
//           plus the OR of all selects (slots consumed by this beat).
//   mask - remaining slot mask
//   sel  - per-lane one-hot slot selects
//   used - slots picked by any lane
// Revision: 1.0 - initial release
// ============================================================================
module first_n_picker
  import inst_group_splitter_pkg::*;
#(
  parameter int unsigned ISSUE_W = 2
) (
  input  logic [GROUP_W-1:0]              mask,
  output logic [ISSUE_W-1:0][GROUP_W-1:0] sel,
  output logic [GROUP_W-1:0]              used
);

  logic [GROUP_W-1:0] w_rest;

  always_comb begin
    w_rest = mask;
    sel    = '0;
    used   = '0;
    for (int j = 0; j < int'(ISSUE_W); j++) begin
      // x & -x isolates the lowest set bit; strip it and move to the next lane.
      sel[j] = w_rest & (~w_rest + {{(GROUP_W-1){1'b0}}, 1'b1});
      w_rest = w_rest & ~sel[j];
      used   = used | sel[j];
    end
  end

endmodule
`default_nettype wire

// File: rtl/inst_group_splitter.sv
`default_nettype none
// ============================================================================
// Module  : inst_group_splitter
// Purpose : Holds one 4-wide fetch group and issues up to ISSUE_W of its
//           valid slots per cycle, in program order, compacted into lanes
//           starting at lane 0, each with a full 32-bit PC.
//   clk - clock, rising edge
//   rst - synchronous active-high reset
//   bus - splitter side of inst_group_splitter_if (group in / lanes out)
// Revision: 1.0 - initial release
// ============================================================================
module inst_group_splitter
  import inst_group_splitter_pkg::*;
#(
  parameter int unsigned ISSUE_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  inst_group_splitter_if.slave  bus
);

  logic [INST_W*GROUP_W-1:0]      r_hold_inst;
  logic [GRP_PC_W-1:0]            r_hold_pc;
  logic [GROUP_W-1:0]             r_rem_mask;

  logic [ISSUE_W-1:0][GROUP_W-1:0] w_sel;
  logic [GROUP_W-1:0]             w_used;
  logic [INST_W*ISSUE_W-1:0]      w_lane_inst;
  logic [INST_W*ISSUE_W-1:0]      w_lane_pc;
  logic [ISSUE_W-1:0]             w_lane_valid;
  logic [2:0]                     w_rem_cnt;
  logic                           w_last_beat;
  logic                           w_out_valid;
  logic                           w_out_ready;
  logic                           w_load;
  logic                           w_issue;

  first_n_picker #(
    .ISSUE_W (ISSUE_W)
  ) u_picker (
    .mask (r_rem_mask),
    .sel  (w_sel),
    .used (w_used)
  );

  // Lane muxes: an empty lane drives zero on all fields.
  always_comb begin
    w_lane_inst  = '0;
    w_lane_pc    = '0;
    w_lane_valid = '0;
    for (int j = 0; j < int'(ISSUE_W); j++) begin
      w_lane_valid[j] = |w_sel[j];
      for (int k = 0; k < int'(GROUP_W); k++) begin
        if (w_sel[j][k]) begin
          w_lane_inst[INST_W*j +: INST_W] = r_hold_inst[INST_W*k +: INST_W];
          w_lane_pc[INST_W*j +: INST_W]   = {r_hold_pc, SLOT_W'(k), 2'b00};
        end
      end
    end
  end

  assign w_rem_cnt   = popcount_mask(r_rem_mask);
  assign w_last_beat = ({29'd0, w_rem_cnt} <= 32'(ISSUE_W));
  assign w_out_valid = |w_lane_valid;

  // next_ready feeds out_ready combinationally so a new group can load on
  // the same edge the final beat of the current one issues.
  assign w_out_ready = !bus.flush &&
                       ((r_rem_mask == '0) || (bus.next_ready && w_last_beat));
  assign w_load      = bus.pre_valid && w_out_ready;
  assign w_issue     = w_out_valid && bus.next_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_inst <= '0;
      r_hold_pc   <= '0;
      r_rem_mask  <= '0;
    end else if (bus.flush) begin
      r_rem_mask  <= '0;
    end else if (w_load) begin
      // A load supersedes the clear of a same-cycle final beat.
      r_hold_inst <= bus.inst_4W;
      r_hold_pc   <= bus.inst_4W_pc;
      r_rem_mask  <= bus.inst_4W_valid;
    end else if (w_issue) begin
      r_rem_mask  <= r_rem_mask & ~w_used;
    end
  end

  assign bus.out_ready   = w_out_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.issue_valid = w_lane_valid;
  assign bus.issue_inst  = w_lane_inst;
  assign bus.issue_pc    = w_lane_pc;

endmodule
`default_nettype wire

// File: tb/tb_inst_group_splitter.sv
`default_nettype none
// ============================================================================
// Module  : tb_inst_group_splitter
// Purpose : Scoreboard bench for inst_group_splitter at ISSUE_W=2. Stimulus
//           pushes hand-computed beats; a monitor pops and compares each
//           accepted beat. Handshake and boundary points are checked inline.
// Revision: 1.0 - initial release
// ============================================================================
module tb_inst_group_splitter;

  typedef struct {
    logic [63:0] inst;
    logic [63:0] pc;
    logic [1:0]  valid;
  } beat_t;

  logic clk;
  logic rst;

  inst_group_splitter_if #(.ISSUE_W(2)) bif ();

  inst_group_splitter #(.ISSUE_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  beat_t sb[$];
  beat_t exp_b;
  int    n_checks = 0;
  int    n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i3, input logic [31:0] i2,
                       input logic [31:0] i1, input logic [31:0] i0,
                       input logic [3:0] mask, input logic [27:0] pc);
    bif.inst_4W       = {i3, i2, i1, i0};
    bif.inst_4W_valid = mask;
    bif.inst_4W_pc    = pc;
    bif.pre_valid     = 1'b1;
  endtask

  task automatic push(input logic [31:0] inst1, input logic [31:0] inst0,
                      input logic [31:0] pc1, input logic [31:0] pc0,
                      input logic [1:0] valid);
    beat_t b;
    b.inst  = {inst1, inst0};
    b.pc    = {pc1, pc0};
    b.valid = valid;
    sb.push_back(b);
  endtask

  // Monitor: every beat decode accepts must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && bif.out_valid && bif.next_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_beat: got inst %h pc %h valid %b, required no beat",
                 bif.issue_inst, bif.issue_pc, bif.issue_valid);
      end else begin
        exp_b = sb.pop_front();
        chk("beat_valid", {62'd0, bif.issue_valid}, {62'd0, exp_b.valid});
        chk("beat_inst",  bif.issue_inst, exp_b.inst);
        chk("beat_pc",    bif.issue_pc,   exp_b.pc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst               = 1'b1;
    bif.flush         = 1'b0;
    bif.inst_4W       = '0;
    bif.inst_4W_valid = '0;
    bif.inst_4W_pc    = '0;
    bif.pre_valid     = 1'b0;
    bif.next_ready    = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid",   {63'd0, bif.out_valid}, 64'd0);
    chk("rst_out_ready",   {63'd0, bif.out_ready}, 64'd1);
    chk("rst_issue_valid", {62'd0, bif.issue_valid}, 64'd0);
    chk("rst_issue_inst",  bif.issue_inst, 64'd0);
    chk("rst_issue_pc",    bif.issue_pc, 64'd0);
    tick();

    // 1: full groups back to back, no bubble
    bif.next_ready = 1'b1;
    drive(32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000, 4'b1111, 28'h0001000);
    push(32'hA000_0001, 32'hA000_0000, 32'h0001_0004, 32'h0001_0000, 2'b11);
    push(32'hA000_0003, 32'hA000_0002, 32'h0001_000C, 32'h0001_0008, 2'b11);
    push(32'hB000_0001, 32'hB000_0000, 32'h0002_0004, 32'h0002_0000, 2'b11);
    push(32'hB000_0003, 32'hB000_0002, 32'h0002_000C, 32'h0002_0008, 2'b11);
    @(negedge clk);
    chk("t1_empty_ready", {63'd0, bif.out_ready}, 64'd1);
    tick();
    drive(32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000, 4'b1111, 28'h0002000);
    @(negedge clk);
    chk("t1_beat1_valid", {63'd0, bif.out_valid}, 64'd1);
    chk("t1_beat1_ready", {63'd0, bif.out_ready}, 64'd0);
    tick();
    @(negedge clk);
    chk("t1_beat2_ready", {63'd0, bif.out_ready}, 64'd1);
    tick();
    bif.pre_valid = 1'b0;
    @(negedge clk);
    chk("t1_no_bubble", {63'd0, bif.out_valid}, 64'd1);
    tick();
    @(negedge clk);
    chk("t1_b_beat2_ready", {63'd0, bif.out_ready}, 64'd1);
    tick();
    @(negedge clk);
    chk("t1_drained", {63'd0, bif.out_valid}, 64'd0);
    tick();

    // 2: sparse mask 0110 issues in one beat
    drive(32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000, 4'b0110, 28'h0003000);
    push(32'hC000_0002, 32'hC000_0001, 32'h0003_0008, 32'h0003_0004, 2'b11);
    @(negedge clk);
    tick();
    bif.pre_valid = 1'b0;
    @(negedge clk);
    chk("t2_out_valid", {63'd0, bif.out_valid}, 64'd1);
    chk("t2_out_ready", {63'd0, bif.out_ready}, 64'd1);
    tick();

    // 3: single high slot lands on lane 0
    drive(32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000, 4'b1000, 28'h0004000);
    push(32'h0000_0000, 32'hD000_0003, 32'h0000_0000, 32'h0004_000C, 2'b01);
    @(negedge clk);
    tick();
    bif.pre_valid = 1'b0;
    @(negedge clk);
    chk("t3_issue_valid", {62'd0, bif.issue_valid}, 64'd1);
    tick();

    // 4: stall for 3 cycles then release
    bif.next_ready = 1'b0;
    drive(32'hE000_0003, 32'hE000_0002, 32'hE000_0001, 32'hE000_0000, 4'b1111, 28'h0005000);
    @(negedge clk);
    chk("t4_load_ready", {63'd0, bif.out_ready}, 64'd1);
    tick();
    bif.pre_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_stall_ready", {63'd0, bif.out_ready}, 64'd0);
      chk("t4_stall_inst",  bif.issue_inst, {32'hE000_0001, 32'hE000_0000});
      chk("t4_stall_pc",    bif.issue_pc,   {32'h0005_0004, 32'h0005_0000});
      tick();
    end
    bif.next_ready = 1'b1;
    push(32'hE000_0001, 32'hE000_0000, 32'h0005_0004, 32'h0005_0000, 2'b11);
    push(32'hE000_0003, 32'hE000_0002, 32'h0005_000C, 32'h0005_0008, 2'b11);
    @(negedge clk);
    chk("t4_rel_ready", {63'd0, bif.out_ready}, 64'd0);
    tick();
    @(negedge clk);
    chk("t4_last_ready", {63'd0, bif.out_ready}, 64'd1);
    tick();
    @(negedge clk);
    chk("t4_drained", {63'd0, bif.out_valid}, 64'd0);
    tick();

    // 5: mask-0 group then single-slot group
    drive(32'hF000_0003, 32'hF000_0002, 32'hF000_0001, 32'hF000_0000, 4'b0000, 28'h0006000);
    @(negedge clk);
    chk("t5_m0_ready", {63'd0, bif.out_ready}, 64'd1);
    tick();
    drive(32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000, 4'b0001, 28'h0007000);
    push(32'h0000_0000, 32'h1000_0000, 32'h0000_0000, 32'h0007_0000, 2'b01);
    @(negedge clk);
    chk("t5_m0_out_valid", {63'd0, bif.out_valid}, 64'd0);
    chk("t5_m0_out_ready", {63'd0, bif.out_ready}, 64'd1);
    tick();
    bif.pre_valid = 1'b0;
    @(negedge clk);
    chk("t5_g_out_valid", {63'd0, bif.out_valid}, 64'd1);
    tick();

    // 6a: flush during beat 1 with another group pending upstream
    bif.next_ready = 1'b0;
    drive(32'h2000_0003, 32'h2000_0002, 32'h2000_0001, 32'h2000_0000, 4'b1111, 28'h0008000);
    @(negedge clk);
    tick();
    drive(32'h3000_0003, 32'h3000_0002, 32'h3000_0001, 32'h3000_0000, 4'b1111, 28'h0009000);
    bif.flush = 1'b1;
    @(negedge clk);
    chk("t6_flush_ready", {63'd0, bif.out_ready}, 64'd0);
    chk("t6_held_valid",  {63'd0, bif.out_valid}, 64'd1);
    tick();
    bif.flush      = 1'b0;
    bif.next_ready = 1'b1;
    push(32'h3000_0001, 32'h3000_0000, 32'h0009_0004, 32'h0009_0000, 2'b11);
    push(32'h3000_0003, 32'h3000_0002, 32'h0009_000C, 32'h0009_0008, 2'b11);
    @(negedge clk);
    chk("t6_post_flush_valid", {63'd0, bif.out_valid}, 64'd0);
    chk("t6_post_flush_ready", {63'd0, bif.out_ready}, 64'd1);
    tick();
    bif.pre_valid = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    tick();

    // 6b: reset mid-group
    bif.next_ready = 1'b0;
    drive(32'h4000_0003, 32'h4000_0002, 32'h4000_0001, 32'h4000_0000, 4'b1111, 28'h000A000);
    @(negedge clk);
    tick();
    bif.pre_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_pre_rst_valid", {63'd0, bif.out_valid}, 64'd1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_out_valid",   {63'd0, bif.out_valid}, 64'd0);
    chk("t6_rst_issue_valid", {62'd0, bif.issue_valid}, 64'd0);
    chk("t6_rst_issue_inst",  bif.issue_inst, 64'd0);
    chk("t6_rst_issue_pc",    bif.issue_pc, 64'd0);
    chk("t6_rst_out_ready",   {63'd0, bif.out_ready}, 64'd1);
    tick();
    tick();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
